// File: rtl/flash_page_load_scheduler.sv
// Arbitrates the shared QSPI read port among cache pages and picks the victim page on an automatic-paging miss.
// Grant is registered one cycle after requestLoad; qspi_* are muxed only while GRANTED, and pages wait on pageLoading for access.
module flash_page_load_scheduler #(
    parameter int ADDRESS_SIZE            = 24,
    parameter int PAGE_INDEX_ADDRESS_SIZE = 3,
    parameter int PAGE_COUNT              = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               automaticPaging,
    input  logic                               readEnable,
    input  logic [PAGE_COUNT-1:0]              page_pageValid,
    input  logic [PAGE_COUNT-1:0]              page_requestLoad,
    input  logic [PAGE_COUNT-1:0]              page_changeAddress,
    input  logic [PAGE_COUNT-1:0]              page_requestData,
    input  logic [PAGE_COUNT*ADDRESS_SIZE-1:0] page_address,
    output logic [PAGE_COUNT-1:0]              page_pageLoading,
    output logic [PAGE_COUNT-1:0]              page_pageSelected,
    input  logic                               qspi_busy,
    output logic [ADDRESS_SIZE-1:0]            qspi_address,
    output logic                               qspi_changeAddress,
    output logic                               qspi_requestData,
    output logic [PAGE_INDEX_ADDRESS_SIZE-1:0] activePage,
    output logic                               loadActive
);

    localparam int W = PAGE_INDEX_ADDRESS_SIZE;

    typedef enum logic [1:0] {IDLE, GRANTED, DRAIN} state_t;

    state_t                state;
    logic [W-1:0]          grant;
    logic [W-1:0]          rr_ptr;
    logic [W-1:0]          victim_ptr;
    logic                  victim_bumped;
    logic [PAGE_COUNT-1:0] req_q;

    logic [W-1:0]          sel_idx;
    logic                  any_valid;
    logic                  miss;
    logic [W-1:0]          next_grant;
    logic [W-1:0]          scan_idx;
    logic                  has_req;

    // Lowest-index valid page wins; on a miss the FIFO victim pointer is used.
    always_comb begin
        any_valid = 1'b0;
        sel_idx   = victim_ptr;
        for (int i = PAGE_COUNT - 1; i >= 0; i--) begin
            if (page_pageValid[i]) begin
                sel_idx   = W'(i);
                any_valid = 1'b1;
            end
        end
        page_pageSelected = automaticPaging ? (PAGE_COUNT'(1) << sel_idx) : '1;
        miss              = automaticPaging && readEnable && !any_valid;
    end

    // Round-robin from rr_ptr+1; the stalled reader's page overrides it.
    always_comb begin
        has_req    = 1'b0;
        next_grant = rr_ptr;
        scan_idx   = rr_ptr;
        for (int i = PAGE_COUNT; i >= 1; i--) begin
            scan_idx = rr_ptr + W'(i);
            if (page_requestLoad[scan_idx]) begin
                next_grant = scan_idx;
                has_req    = 1'b1;
            end
        end
        if (automaticPaging && page_requestLoad[sel_idx]) begin
            next_grant = sel_idx;
            has_req    = 1'b1;
        end
    end

    always_comb begin
        qspi_address       = '0;
        qspi_changeAddress = 1'b0;
        qspi_requestData   = 1'b0;
        if (state == GRANTED) begin
            for (int i = 0; i < PAGE_COUNT; i++) begin
                if (grant == W'(i)) begin
                    qspi_address = page_address[i*ADDRESS_SIZE +: ADDRESS_SIZE];
                end
            end
            qspi_changeAddress = page_changeAddress[grant];
            qspi_requestData   = page_requestData[grant];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            grant            <= '0;
            rr_ptr           <= W'(PAGE_COUNT - 1);
            victim_ptr       <= '0;
            victim_bumped    <= 1'b0;
            req_q            <= '0;
            page_pageLoading <= '0;
            loadActive       <= 1'b0;
            activePage       <= '0;
        end else begin
            req_q <= page_requestLoad;

            // One advance per miss episode, on the victim's requestLoad rising edge.
            if (!miss) begin
                victim_bumped <= 1'b0;
            end else if (!victim_bumped && page_requestLoad[victim_ptr] && !req_q[victim_ptr]) begin
                victim_ptr    <= victim_ptr + W'(1);
                victim_bumped <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (has_req) begin
                        grant            <= next_grant;
                        activePage       <= next_grant;
                        page_pageLoading <= PAGE_COUNT'(1) << next_grant;
                        loadActive       <= 1'b1;
                        state            <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (!page_requestLoad[grant]) begin
                        page_pageLoading <= '0;
                        loadActive       <= 1'b0;
                        state            <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!qspi_busy) begin
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_page_load_scheduler.sv
// Directed bench for flash_page_load_scheduler: arbitration order, drain timing, victim selection and reset.
module tb_flash_page_load_scheduler;

    logic         clk = 1'b0;
    logic         rst;
    logic         automaticPaging;
    logic         readEnable;
    logic [7:0]   page_pageValid;
    logic [7:0]   page_requestLoad;
    logic [7:0]   page_changeAddress;
    logic [7:0]   page_requestData;
    logic [191:0] page_address;
    logic [7:0]   page_pageLoading;
    logic [7:0]   page_pageSelected;
    logic         qspi_busy;
    logic [23:0]  qspi_address;
    logic         qspi_changeAddress;
    logic         qspi_requestData;
    logic [2:0]   activePage;
    logic         loadActive;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    flash_page_load_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .automaticPaging    (automaticPaging),
        .readEnable         (readEnable),
        .page_pageValid     (page_pageValid),
        .page_requestLoad   (page_requestLoad),
        .page_changeAddress (page_changeAddress),
        .page_requestData   (page_requestData),
        .page_address       (page_address),
        .page_pageLoading   (page_pageLoading),
        .page_pageSelected  (page_pageSelected),
        .qspi_busy          (qspi_busy),
        .qspi_address       (qspi_address),
        .qspi_changeAddress (qspi_changeAddress),
        .qspi_requestData   (qspi_requestData),
        .activePage         (activePage),
        .loadActive         (loadActive)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until loadActive appears (bounded), then checks latency and the grantee.
    task automatic wait_grant(input int p, input int exp_cycles);
        int n;
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (loadActive) break;
        end
        chk($sformatf("grant%0d_latency", p), n, exp_cycles);
        chk($sformatf("grant%0d_active", p), {29'd0, activePage}, p);
        chk($sformatf("grant%0d_onehot", p), {24'd0, page_pageLoading}, 32'd1 << p);
    endtask

    initial begin
        rst                = 1'b1;
        automaticPaging    = 1'b0;
        readEnable         = 1'b0;
        page_pageValid     = '0;
        page_requestLoad   = '0;
        page_changeAddress = 8'h08;
        page_requestData   = 8'hFF;
        qspi_busy          = 1'b0;
        for (int i = 0; i < 8; i++) page_address[i*24 +: 24] = 24'h010000 * i + 24'h000100;
        page_address[3*24 +: 24] = 24'h001000;

        repeat (3) step();
        chk("rst_loading", {24'd0, page_pageLoading}, 0);
        chk("rst_active", {31'd0, loadActive}, 0);
        chk("rst_page", {29'd0, activePage}, 0);
        chk("rst_addr", {8'd0, qspi_address}, 0);
        chk("rst_rdata", {31'd0, qspi_requestData}, 0);
        chk("manual_sel", {24'd0, page_pageSelected}, 32'hFF);
        rst = 1'b0;
        step();

        // Single request from page 3
        page_requestLoad[3] = 1'b1;
        step();
        chk("p3_loading", {24'd0, page_pageLoading}, 32'h08);
        chk("p3_page", {29'd0, activePage}, 3);
        chk("p3_addr", {8'd0, qspi_address}, 32'h001000);
        chk("p3_chg", {31'd0, qspi_changeAddress}, 1);
        chk("p3_rdata", {31'd0, qspi_requestData}, 1);
        chk("p3_la", {31'd0, loadActive}, 1);
        page_requestLoad[3] = 1'b0;
        step();
        chk("p3_drain_loading", {24'd0, page_pageLoading}, 0);
        chk("p3_drain_rdata", {31'd0, qspi_requestData}, 0);
        chk("p3_drain_addr", {8'd0, qspi_address}, 0);
        chk("p3_hold_page", {29'd0, activePage}, 3);
        step();

        // Make rrPointer = 1, then 1/2/5 together -> order 2, 5, 1
        page_requestLoad[1] = 1'b1;
        wait_grant(1, 1);
        page_requestLoad[1] = 1'b0;
        step();
        step();
        page_requestLoad = 8'b0010_0110;
        wait_grant(2, 1);
        page_requestLoad[2] = 1'b0;
        wait_grant(5, 3);
        page_requestLoad[5] = 1'b0;
        wait_grant(1, 3);
        page_requestLoad[1] = 1'b0;
        step();
        step();

        // Drain held by qspi_busy for 4 cycles
        page_requestLoad[6] = 1'b1;
        wait_grant(6, 1);
        page_requestLoad[6] = 1'b0;
        page_requestLoad[4] = 1'b1;
        qspi_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("busy_hold_la%0d", i), {31'd0, loadActive}, 0);
            chk($sformatf("busy_hold_ld%0d", i), {24'd0, page_pageLoading}, 0);
        end
        qspi_busy = 1'b0;
        wait_grant(4, 2);
        page_requestLoad[4] = 1'b0;
        step();
        step();

        // Victim pointer walk through all pages, then wrap
        automaticPaging = 1'b1;
        readEnable      = 1'b1;
        #1;
        chk("victim_start", {24'd0, page_pageSelected}, 32'h01);
        for (int k = 0; k < 7; k++) begin
            readEnable          = 1'b1;
            page_requestLoad[k] = 1'b1;
            step();
            chk($sformatf("victim_adv%0d", k), {24'd0, page_pageSelected}, 32'd1 << (k + 1));
            if (k == 0) begin
                page_requestLoad[1] = 1'b1;
                step();
                chk("victim_once", {24'd0, page_pageSelected}, 32'h02);
            end
            readEnable       = 1'b0;
            page_requestLoad = '0;
            repeat (3) step();
        end
        chk("victim_7", {24'd0, page_pageSelected}, 32'h80);
        readEnable          = 1'b1;
        page_requestLoad[7] = 1'b1;
        step();
        chk("victim_wrap", {24'd0, page_pageSelected}, 32'h01);
        readEnable       = 1'b0;
        page_requestLoad = '0;
        repeat (3) step();
        page_pageValid = 8'b0010_0100;
        #1;
        chk("valid_lowest", {24'd0, page_pageSelected}, 32'h04);
        page_pageValid = '0;

        // Selected page beats round-robin with rrPointer = 7
        automaticPaging     = 1'b0;
        page_requestLoad[7] = 1'b1;
        wait_grant(7, 1);
        page_requestLoad = '0;
        step();
        step();
        automaticPaging  = 1'b1;
        page_pageValid   = 8'h04;
        page_requestLoad = 8'b0000_0101;
        wait_grant(2, 1);
        page_requestLoad[2] = 1'b0;
        wait_grant(0, 3);
        page_requestLoad = '0;
        step();
        step();
        automaticPaging = 1'b0;
        page_pageValid  = '0;

        // Reset in the middle of a grant
        page_requestLoad[3] = 1'b1;
        wait_grant(3, 1);
        chk("pre_rst_rdata", {31'd0, qspi_requestData}, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_loading", {24'd0, page_pageLoading}, 0);
        chk("mid_rst_rdata", {31'd0, qspi_requestData}, 0);
        chk("mid_rst_la", {31'd0, loadActive}, 0);
        chk("mid_rst_page", {29'd0, activePage}, 0);
        rst              = 1'b0;
        page_requestLoad = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
